// File: rtl/led_fade_driver.sv
// led_fade_driver: per-channel PWM LED driver that cross-fades
// a 4-bit running-light pattern by ramping duty up and down.
module led_fade_driver #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 196_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] led_in,
  output logic [3:0] led_out,
  output logic       busy
);

  localparam int SW = $clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_RISE,
    S_ON,
    S_FALL
  } ch_state_t;

  logic [3:0]          led_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SW-1:0]       step_cnt;
  logic                tick;

  ch_state_t           state_q [4];
  ch_state_t           state_d [4];
  logic [PWM_BITS-1:0] duty_q  [4];
  logic [PWM_BITS-1:0] duty_d  [4];
  logic [3:0]          ramping;
  logic [3:0]          pwm_bit;

  assign tick = (step_cnt == STEP_LAST);

  // Input register, free-running PWM counter and ramp tick divider.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led_q    <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      led_q    <= led_in;
      pwm_cnt  <= pwm_cnt + 1'b1;
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
    end
  end

  // Per-channel ramp state and duty registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= S_OFF;
        duty_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  // Ramp next-state: the tick acts on the current state, a reversal
  // keeps the current duty so the fade continues without a jump.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      unique case (state_q[i])
        S_OFF: begin
          duty_d[i] = '0;
          if (led_q[i]) state_d[i] = S_RISE;
        end
        S_RISE: begin
          if (tick && duty_q[i] != MAX)
            duty_d[i] = duty_q[i] + 1'b1;
          if (!led_q[i])
            state_d[i] = S_FALL;
          else if (duty_d[i] == MAX)
            state_d[i] = S_ON;
        end
        S_ON: begin
          duty_d[i] = MAX;
          if (!led_q[i]) state_d[i] = S_FALL;
        end
        S_FALL: begin
          if (tick && duty_q[i] != '0)
            duty_d[i] = duty_q[i] - 1'b1;
          if (led_q[i])
            state_d[i] = S_RISE;
          else if (duty_d[i] == '0)
            state_d[i] = S_OFF;
        end
      endcase
    end
  end

  // PWM compare and ramp activity per channel.
  always_comb begin
    ramping = '0;
    pwm_bit = '0;
    for (int i = 0; i < 4; i++) begin
      ramping[i] = (state_q[i] == S_RISE) ||
                   (state_q[i] == S_FALL);
      pwm_bit[i] = (duty_q[i] == MAX) ||
                   (pwm_cnt < duty_q[i]);
    end
  end

  // Registered LED drive and busy flag.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led_out <= '0;
      busy    <= 1'b0;
    end else begin
      led_out <= pwm_bit;
      busy    <= |ramping;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: scoreboard bench; a duty-level model predicts
// led_out/busy per clock, a monitor compares on the falling edge.
module tb_led_fade_driver;

  localparam int PB   = 4;
  localparam int SD   = 4;
  localparam int MAXV = 15;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [3:0] led_in  = 4'b0000;
  logic [3:0] led_out;
  logic       busy;

  led_fade_driver #(
    .PWM_BITS(PB),
    .STEP_DIV(SD)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .led_in (led_in),
    .led_out(led_out),
    .busy   (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [3:0] led;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int         m_duty[4];
  int         m_pwm;
  int         m_step;
  logic [3:0] m_lq;
  logic [3:0] m_tgt;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
    m_pwm  = 0;
    m_step = 0;
    m_lq   = '0;
    m_tgt  = '0;
  endfunction

  // One clock of the model. Each channel's duty walks one step per
  // tick toward 0 or MAX, aiming at led_in as seen two clocks ago;
  // busy reports a channel not yet at its target level.
  function automatic void model_edge();
    exp_t e;
    int   lvl;
    logic tk;
    tk     = (m_step == SD - 1);
    e.busy = 1'b0;
    e.led  = '0;
    for (int i = 0; i < 4; i++) begin
      lvl = m_tgt[i] ? MAXV : 0;
      if (m_duty[i] != lvl) e.busy = 1'b1;
      e.led[i] = (m_duty[i] == MAXV) || (m_pwm < m_duty[i]);
      if (tk && m_duty[i] != lvl)
        m_duty[i] += m_tgt[i] ? 1 : -1;
    end
    m_pwm  = (m_pwm + 1) % (MAXV + 1);
    m_step = (m_step + 1) % SD;
    m_tgt  = m_lq;
    m_lq   = led_in;
    exp_q.push_back(e);
  endfunction

  // Monitor: every clock the DUT presents one output sample.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led_out", 32'(led_out), 32'(e.led));
      check("busy", 32'(busy), 32'(e.busy));
    end
  end

  task automatic step(input logic [3:0] v, input int n);
    repeat (n) begin
      @(negedge sys_clk);
      led_in = v;
      @(posedge sys_clk);
      model_edge();
    end
  endtask

  // Asserts reset between edges, checks outputs clear at once and
  // stay clear, then releases with led_in = v.
  task automatic do_reset(input int n, input logic [3:0] v);
    #2;
    sys_rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_led_now", 32'(led_out), 32'h0);
    check("rst_busy_now", 32'(busy), 32'h0);
    repeat (n) begin
      @(negedge sys_clk);
      check("rst_led_hold", 32'(led_out), 32'h0);
      check("rst_busy_hold", 32'(busy), 32'h0);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    led_in  = v;
    @(posedge sys_clk);
    model_edge();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] v;
    int         n;
    model_reset();
    do_reset(3, 4'b0001);
    step(4'b0001, 75);
    check("rise_done_led", 32'(led_out), 32'h1);
    check("rise_done_busy", 32'(busy), 32'h0);
    step(4'b0010, 75);
    check("xfade_led", 32'(led_out), 32'h2);
    step(4'b0000, 70);
    step(4'b0001, 30);
    step(4'b0000, 40);
    step(4'b0001, 70);
    step(4'b0010, 30);
    do_reset(4, 4'b0010);
    step(4'b0010, 75);
    check("rerise_led", 32'(led_out), 32'h2);
    for (int k = 0; k < 25; k++) begin
      v = 4'($urandom_range(0, 15));
      n = $urandom_range(12, 60);
      step(v, n);
    end
    @(negedge sys_clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Downstream output stage for the running-light (water LED) pattern generator. Takes the 4-bit one-hot LED pattern and drives the board LEDs through per-channel PWM. When a channel turns on it ramps up in brightness; when it turns off it ramps down, so the running light cross-fades instead of hard-switching.

## Interface
- PWM_BITS, 8: width of the PWM counter and of each duty register; MAX = 2^PWM_BITS - 1.
- STEP_DIV, 196_000: clocks per brightness step (ramp tick period); ≥ 2.
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  reset, asynchronous, active-high; one clock, asynchronous active-high reset.
- led_in  input  4  target pattern from the pattern generator, synchronous to sys_clk; bit i = 1 means channel i targets full brightness.
- led_out  output  4  PWM-modulated LED drive, registered.
- busy  output  1  high while any channel is ramping.

## Operation
- Input register: led_q <= led_in every clock. All ramp decisions use led_q, never led_in directly.
- PWM counter pwm_cnt is free-running, PWM_BITS wide, 0..MAX, and wraps MAX -> 0.
- Tick counter step_cnt counts 0..STEP_DIV-1 and wraps. tick = (step_cnt == STEP_DIV-1).
- Each channel i has duty[i] (PWM_BITS wide, unsigned) and a 2-bit state:
  - OFF: duty = 0, led_q[i] = 0. If led_q[i] = 1, go to RISE.
  - RISE: on tick, duty += 1. When the step reaches MAX, go to ON. If led_q[i] = 0, go to FALL with no duty jump.
  - ON: duty = MAX. If led_q[i] = 0, go to FALL.
  - FALL: on tick, duty -= 1. When the step reaches 0, go to OFF. If led_q[i] = 1, go to RISE with no duty jump.
- Duty saturates: no wrap past MAX or below 0.
- Per-channel output: led_out[i] <= (duty[i] == MAX) | (pwm_cnt < duty[i]).
  - duty 0 gives a constant 0.
  - duty MAX gives a constant 1.
  - duty d gives d high cycles per 2^PWM_BITS-cycle period.
- busy <= OR over channels of (state == RISE or FALL).
- Channels are independent. Any number may ramp at the same time, and non-one-hot inputs are legal.

## Timing
- Reset values: led_out = 0, busy = 0, led_q = 0, all duty = 0, all states OFF, pwm_cnt = 0, step_cnt = 0.
- Reset asserted mid-ramp: all registers take their reset values immediately, without waiting for a clock edge. Ramping resumes from duty 0 after release.
- led_in change at edge t:
  - led_q updates at t+1.
  - The state transition happens at t+2.
  - busy rises at t+3.
  - The first duty step happens on the first tick after the state has changed.
- Full ramp 0 -> MAX takes MAX ticks, i.e. MAX × STEP_DIV clocks, with up to one STEP_DIV of start jitter.
- led_out lags duty/pwm_cnt by one clock.
- A tick in the same cycle as a state change is applied according to the pre-change state.
- A reversal mid-ramp continues from the current duty; no step is skipped or repeated.
- busy falls one clock after the last ramping channel enters ON or OFF.

## Test plan
Use PWM_BITS = 4 (MAX = 15) and STEP_DIV = 4.
- Reset: assert sys_rst asynchronously between edges -> led_out = 0000 and busy = 0 immediately. Both hold for the whole reset.
- Rise: hold led_in = 0001 from reset release.
  - duty[0] increments once per 4 clocks and reaches 15 in ≤ 64 clocks.
  - busy drops and led_out[0] then stays 1.
  - led_out[3:1] stay 0 throughout.
- PWM shape: freeze channel 0 at duty 5 (force via ramp timing) -> led_out[0] is high exactly 5 of every 16 clocks, aligned to pwm_cnt 0..4.
- Cross-fade: with ch0 ON, switch led_in to 0010.
  - ch0 steps 15 -> 0 while ch1 steps 0 -> 15 on the same ticks, so duty[0] + duty[1] = 15 at every tick.
  - busy stays high for 15 ticks.
- Reversal: led_in 0001, then 0000 after ch0 reaches duty 7 -> duty[0] goes 7, 6, 5 … 0, with no value above 7.
- Mid-fade reset: pulse sys_rst during the cross-fade -> all outputs are 0. After release with led_in = 0010, ch1 ramps again from 0.
